// File: rtl/pc_bus_pkg.sv
// Shared types and widths for the PC bus wait-state logic.
package pc_bus_pkg;

    localparam int WAIT_W = 4;
    localparam int TO_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT,
        EXTEND,
        READY,
        DMA
    } state_e;

    // Base wait count for the cycle type presented with the command strobe.
    function automatic logic [WAIT_W-1:0] base_wait(
        input logic              io_i,
        input logic [WAIT_W-1:0] io_w_i,
        input logic [WAIT_W-1:0] mem_w_i
    );
        return io_i ? io_w_i : mem_w_i;
    endfunction

endpackage

// File: rtl/pc_wait_counter.sv
// Base-wait down-counter and iochrdy extension up-counter.
module pc_wait_counter
    import pc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cnt_load_i,
    input  logic [WAIT_W-1:0] cnt_val_i,
    input  logic              cnt_en_i,
    input  logic              to_clr_i,
    input  logic              to_en_i,
    output logic              cnt_last_o,
    output logic              to_term_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;

    assign cnt_last_o = (cnt_q <= WAIT_W'(1));
    assign to_term_o  = (to_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load_i) begin
            cnt_d = cnt_val_i;
        end else if (cnt_en_i && cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    // Terminal compare gates the increment so the counter never wraps.
    always_comb begin
        to_d = to_q;
        if (to_clr_i) begin
            to_d = '0;
        end else if (to_en_i && !to_term_o && to_q != '1) begin
            to_d = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

endmodule

// File: rtl/pc_wait_state_gen.sv
// Wait-state generator driving rdy1/aen1 into the 8284A ready logic.
module pc_wait_state_gen
    import pc_bus_pkg::*;
#(
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic ale,
    input  logic io_cycle,
    input  logic cmd_active,
    input  logic iochrdy,
    input  logic dma_hold,
    output logic rdy1,
    output logic aen1,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] IO_W  = WAIT_W'(IO_WAIT);
    localparam logic [WAIT_W-1:0] MEM_W = WAIT_W'(MEM_WAIT);

    state_e state_q, state_d;
    logic   rdy1_q, rdy1_d;
    logic   aen1_q, aen1_d;
    logic   timeout_q, timeout_d;

    logic              cnt_load, cnt_en, to_clr, to_en;
    logic              cnt_last, to_term;
    logic [WAIT_W-1:0] w;

    pc_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .cnt_load_i (cnt_load),
        .cnt_val_i  (w),
        .cnt_en_i   (cnt_en),
        .to_clr_i   (to_clr),
        .to_en_i    (to_en),
        .cnt_last_o (cnt_last),
        .to_term_o  (to_term)
    );

    always_comb begin
        state_d   = state_q;
        rdy1_d    = rdy1_q;
        aen1_d    = aen1_q;
        timeout_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        to_clr    = 1'b0;
        to_en     = 1'b0;
        w         = base_wait(io_cycle, IO_W, MEM_W);

        unique case (state_q)
            IDLE: begin
                if (dma_hold) begin
                    state_d = DMA;
                    aen1_d  = 1'b1;
                end else if (ale) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (cmd_active) begin
                    if (w == '0 && iochrdy) begin
                        state_d = READY;
                    end else begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                        rdy1_d   = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (!cnt_last) begin
                    cnt_en = 1'b1;
                end else if (iochrdy) begin
                    state_d = READY;
                    rdy1_d  = 1'b1;
                end else begin
                    state_d = EXTEND;
                    to_clr  = 1'b1;
                end
            end
            // A card releasing iochrdy wins over a coincident timeout.
            EXTEND: begin
                if (iochrdy) begin
                    state_d = READY;
                    rdy1_d  = 1'b1;
                end else if (to_term) begin
                    state_d   = READY;
                    rdy1_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    to_en = 1'b1;
                end
            end
            READY: begin
                if (!cmd_active) begin
                    state_d = IDLE;
                end
            end
            DMA: begin
                if (!dma_hold) begin
                    state_d = IDLE;
                    aen1_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rdy1_d  = 1'b1;
                aen1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rdy1_q    <= 1'b1;
            aen1_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy1_q    <= rdy1_d;
            aen1_q    <= aen1_d;
            timeout_q <= timeout_d;
        end
    end

    assign rdy1    = rdy1_q;
    assign aen1    = aen1_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pc_wait_state_gen.sv
// Two differently parameterised generators driven by one directed stimulus stream.
module tb_pc_wait_state_gen;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset, ale, io_cycle, cmd_active, iochrdy, dma_hold;
    logic rdy1_a, aen1_a, to_a;
    logic rdy1_b, aen1_b, to_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_wait_state_gen #(.IO_WAIT(1), .MEM_WAIT(0), .TIMEOUT(TO)) u_a (
        .clk(clk), .reset(reset), .ale(ale), .io_cycle(io_cycle),
        .cmd_active(cmd_active), .iochrdy(iochrdy), .dma_hold(dma_hold),
        .rdy1(rdy1_a), .aen1(aen1_a), .timeout(to_a)
    );

    pc_wait_state_gen #(.IO_WAIT(2), .MEM_WAIT(3), .TIMEOUT(TO)) u_b (
        .clk(clk), .reset(reset), .ale(ale), .io_cycle(io_cycle),
        .cmd_active(cmd_active), .iochrdy(iochrdy), .dma_hold(dma_hold),
        .rdy1(rdy1_b), .aen1(aen1_b), .timeout(to_b)
    );

    logic [1:0] o_rdy, o_aen, o_to;
    assign o_rdy = {rdy1_b, rdy1_a};
    assign o_aen = {aen1_b, aen1_a};
    assign o_to  = {to_b, to_a};

    // Model: a bus cycle is "low" from the arming edge; edge k after that
    // releases when k >= base (min 1) and iochrdy, or forcibly at base+TO.
    int iow[2]  = '{1, 2};
    int memw[2] = '{0, 3};
    int m_mode[2];
    int m_k[2];
    int m_base[2];
    bit m_rdy[2];
    bit m_aen[2];
    bit m_to[2];

    always @(posedge clk or posedge reset) begin : model
        int w;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_mode[d] = 0;
                m_k[d]    = 0;
                m_base[d] = 0;
                m_rdy[d]  = 1'b1;
                m_aen[d]  = 1'b0;
                m_to[d]   = 1'b0;
            end else begin
                m_to[d] = 1'b0;
                case (m_mode[d])
                    0: begin
                        if (dma_hold) begin
                            m_mode[d] = 4;
                            m_aen[d]  = 1'b1;
                        end else if (ale) begin
                            m_mode[d] = 1;
                        end
                    end
                    1: begin
                        if (cmd_active) begin
                            w = io_cycle ? iow[d] : memw[d];
                            if (w == 0 && iochrdy) begin
                                m_mode[d] = 3;
                            end else begin
                                m_mode[d] = 2;
                                m_k[d]    = 0;
                                m_base[d] = (w == 0) ? 1 : w;
                                m_rdy[d]  = 1'b0;
                            end
                        end
                    end
                    2: begin
                        m_k[d] = m_k[d] + 1;
                        if (m_k[d] >= m_base[d]) begin
                            if (iochrdy) begin
                                m_mode[d] = 3;
                                m_rdy[d]  = 1'b1;
                            end else if (m_k[d] == m_base[d] + TO) begin
                                m_mode[d] = 3;
                                m_rdy[d]  = 1'b1;
                                m_to[d]   = 1'b1;
                            end
                        end
                    end
                    3: begin
                        if (!cmd_active) m_mode[d] = 0;
                    end
                    default: begin
                        if (!dma_hold) begin
                            m_mode[d] = 0;
                            m_aen[d]  = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    int lows[2] = '{0, 0};
    int tos[2]  = '{0, 0};

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                lows[d] = lows[d] + (o_rdy[d] ? 0 : 1);
                tos[d]  = tos[d] + (o_to[d] ? 1 : 0);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic bus_cycle(input bit io, input int nlow,
                             output int la, output int lb,
                             output int ta, output int tb_);
        int l0a, l0b, t0a, t0b;
        @(negedge clk);
        #1;
        l0a = lows[0]; l0b = lows[1];
        t0a = tos[0];  t0b = tos[1];
        ale = 1'b1;
        @(negedge clk);
        ale        = 1'b0;
        cmd_active = 1'b1;
        io_cycle   = io;
        iochrdy    = (nlow == 0);
        for (int i = 0; i < nlow + 8; i++) begin
            @(negedge clk);
            if (i + 1 == nlow) iochrdy = 1'b1;
        end
        cmd_active = 1'b0;
        iochrdy    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        la  = lows[0] - l0a;
        lb  = lows[1] - l0b;
        ta  = tos[0] - t0a;
        tb_ = tos[1] - t0b;
    endtask

    task automatic cmd_no_ale(output int la, output int lb);
        int l0a, l0b;
        @(negedge clk);
        #1;
        l0a = lows[0]; l0b = lows[1];
        cmd_active = 1'b1;
        io_cycle   = 1'b1;
        iochrdy    = 1'b1;
        repeat (5) @(negedge clk);
        cmd_active = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        la = lows[0] - l0a;
        lb = lows[1] - l0b;
    endtask

    initial begin
        int la, lb, ta, tb_;
        reset = 1'b1; ale = 1'b0; io_cycle = 1'b0;
        cmd_active = 1'b0; iochrdy = 1'b1; dma_hold = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    for (int d = 0; d < 2; d++) begin
                        check($sformatf("cyc_rdy1_%0d", d), o_rdy[d], m_rdy[d]);
                        check($sformatf("cyc_aen1_%0d", d), o_aen[d], m_aen[d]);
                        check($sformatf("cyc_timeout_%0d", d), o_to[d], m_to[d]);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_rdy1_a", rdy1_a, 1);
        check("rst_aen1_b", aen1_b, 0);
        check("rst_to_b", to_b, 0);

        cmd_no_ale(la, lb);
        check("noale_low_a", la, 0);
        check("noale_low_b", lb, 0);

        bus_cycle(1'b1, 0, la, lb, ta, tb_);
        check("io_low_a", la, 1);
        check("io_low_b", lb, 2);
        check("io_to_b", tb_, 0);

        bus_cycle(1'b0, 0, la, lb, ta, tb_);
        check("mem_low_a", la, 0);
        check("mem_low_b", lb, 3);

        bus_cycle(1'b0, 2, la, lb, ta, tb_);
        check("memext_low_a", la, 2);
        check("memext_low_b", lb, 3);

        bus_cycle(1'b1, 5, la, lb, ta, tb_);
        check("ioext_low_a", la, 5);
        check("ioext_low_b", lb, 5);
        check("ioext_to_a", ta, 0);
        check("ioext_to_b", tb_, 0);

        bus_cycle(1'b1, 20, la, lb, ta, tb_);
        check("iotmo_low_a", la, 5);
        check("iotmo_low_b", lb, 6);
        check("iotmo_to_a", ta, 1);
        check("iotmo_to_b", tb_, 1);

        bus_cycle(1'b0, 20, la, lb, ta, tb_);
        check("memtmo_low_a", la, 5);
        check("memtmo_low_b", lb, 7);
        check("memtmo_to_b", tb_, 1);

        // Reset abandoned mid-wait must restore outputs without a clock.
        @(negedge clk);
        ale = 1'b1;
        @(negedge clk);
        ale = 1'b0; cmd_active = 1'b1; io_cycle = 1'b1; iochrdy = 1'b0;
        @(negedge clk);
        #1;
        check("prerst_rdy1_b", rdy1_b, 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rdy1_a", rdy1_a, 1);
        check("async_rdy1_b", rdy1_b, 1);
        check("async_aen1_b", aen1_b, 0);
        check("async_to_b", to_b, 0);
        @(negedge clk);
        reset = 1'b0; cmd_active = 1'b0; iochrdy = 1'b1;
        cmd_no_ale(la, lb);
        check("postrst_low_a", la, 0);
        check("postrst_low_b", lb, 0);

        // DMA request during an I/O cycle is deferred until IDLE.
        @(negedge clk);
        ale = 1'b1;
        @(negedge clk);
        ale = 1'b0; cmd_active = 1'b1; io_cycle = 1'b1; iochrdy = 1'b1;
        @(negedge clk);
        dma_hold = 1'b1;
        #1;
        check("dmawait_aen1_b", aen1_b, 0);
        repeat (3) @(negedge clk);
        cmd_active = 1'b0;
        @(negedge clk);
        #1;
        check("dmaidle_aen1_a", aen1_a, 0);
        check("dmaidle_aen1_b", aen1_b, 0);
        @(negedge clk);
        #1;
        check("dmaon_aen1_a", aen1_a, 1);
        check("dmaon_aen1_b", aen1_b, 1);
        ale = 1'b1;
        @(negedge clk);
        ale = 1'b0;
        repeat (2) @(negedge clk);
        dma_hold = 1'b0;
        @(negedge clk);
        #1;
        check("dmaoff_aen1_a", aen1_a, 0);
        check("dmaoff_aen1_b", aen1_b, 0);
        cmd_no_ale(la, lb);
        check("dmaale_low_b", lb, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_wait_state_gen.md
# pc_wait_state_gen

Bus wait-state generator for the PC motherboard. It produces the `rdy1`/`aen1` pair consumed by `intel8284a`, which synchronises them into CPU READY. It inserts a programmable number of wait states on I/O and memory cycles and stretches cycles while an expansion card holds `iochrdy` low, up to a bounded timeout. It also deselects the CPU ready path while DMA owns the bus.

## Interface

Parameters:
- `IO_WAIT`, default 1: base wait states on I/O cycles, range 0..15.
- `MEM_WAIT`, default 0: base wait states on memory cycles, range 0..15.
- `TIMEOUT`, default 255: maximum `iochrdy`-low extension in clocks, range 1..255.

Ports:
- `clk` in 1: system clock. This block has exactly one clock.
- `reset` in 1: reset, asynchronous and active-high.
- `ale` in 1: address latch enable; marks the start of a bus cycle.
- `io_cycle` in 1: 1 = I/O cycle, 0 = memory cycle. Sampled with `cmd_active`.
- `cmd_active` in 1: any read/write command strobe asserted.
- `iochrdy` in 1: channel ready from cards. 0 extends the cycle.
- `dma_hold` in 1: DMA controller requests the bus.
- `rdy1` out 1: ready request to `intel8284a`. 1 = ready.
- `aen1` out 1: active-low qualifier for `rdy1`. 1 = CPU ready path disabled (DMA).
- `timeout` out 1: one-clock pulse when an extension is forcibly terminated.

## Operation

FSM states: IDLE, ARMED, WAIT, EXTEND, READY, DMA. Reset values: state IDLE, `rdy1`=1, `aen1`=0, `timeout`=0, all counters 0.

Transitions:
- IDLE
  - `dma_hold`=1 → DMA, `aen1`←1. DMA has priority over `ale` in the same clock.
  - `ale`=1 → ARMED.
  - `cmd_active` without a preceding `ale` is ignored.
- ARMED, on a `cmd_active`=1 edge: W = `IO_WAIT` if `io_cycle`, else `MEM_WAIT`.
  - W=0 and `iochrdy`=1 → READY.
  - Otherwise → WAIT, `cnt`←W, `rdy1`←0.
- WAIT
  - `cnt`>1 → `cnt`−−.
  - `cnt`≤1 and `iochrdy`=1 → READY, `rdy1`←1.
  - `cnt`≤1 and `iochrdy`=0 → EXTEND, `to_cnt`←0.
- EXTEND
  - `iochrdy`=1 → READY, `rdy1`←1.
  - `to_cnt`=`TIMEOUT`−1 → READY, `rdy1`←1, `timeout`←1 for one clock.
  - Otherwise `to_cnt`++.
- READY, on `cmd_active`=0 → IDLE.
- DMA, on `dma_hold`=0 → IDLE, `aen1`←0.

Deferral rules:
- `dma_hold` arriving in ARMED, WAIT, EXTEND or READY waits until the FSM returns to IDLE.
- `ale` is ignored in every state other than IDLE.

Widths:
- `cnt` is 4 bits.
- `to_cnt` is 8 bits and never wraps; the terminal compare precedes the increment.

## Timing

- All outputs are registered and change only on `clk` rising edges, except on asynchronous reset.
- With `iochrdy`=1 and W≥1, `rdy1` is low for exactly W clocks, starting at the edge that samples `cmd_active`=1.
- With W=0 and `iochrdy`=0, `rdy1` is low for 1 clock plus the extension.
- Extension: `rdy1` rises on the first edge that samples `iochrdy`=1. If no such edge occurs, it rises `TIMEOUT`+1 clocks after entering WAIT with `cnt`≤1.
- `timeout` is high in the same cycle that `rdy1` returns to 1.
- Reset asserted in any state immediately forces the reset values; a cycle in progress is abandoned.

## Structure

- Shared package `pc_bus_pkg`:
  - state enum.
  - `WAIT_W`=4, `TO_W`=8.
- Sub-module `pc_wait_counter`: the 4-bit base-wait down-counter and the 8-bit timeout up-counter, with load, enable and terminal-count outputs. The FSM stays in the top module.

## Test plan

- Reset sequencing: assert `reset` mid-WAIT → `rdy1`=1, `aen1`=0, `timeout`=0 immediately, without waiting for a clock; after release, IDLE ignores `cmd_active` until `ale`.
- I/O cycle, `IO_WAIT`=1, `iochrdy`=1 → `rdy1` low for exactly 1 clock. Memory cycle, `MEM_WAIT`=0 → `rdy1` never drops.
- I/O cycle, `IO_WAIT`=2, `iochrdy` low for 5 clocks → `rdy1` low 2 clocks plus extension, rising on the first edge with `iochrdy`=1; `timeout` stays 0.
- `iochrdy` held 0, `TIMEOUT`=4 → `rdy1` rises after forced termination and `timeout` pulses for exactly 1 clock in the same cycle.
- `dma_hold` rises during WAIT → `aen1` stays 0 until the cycle ends. Then `aen1`=1 one clock after IDLE and returns to 0 one clock after `dma_hold` falls. `ale` during DMA is ignored.
